// File: rtl/otbn_mac_bignum_mulseq_if.sv
// Bundle between the multiply sequencer, its controller and the bignum MAC.
// Handshakes: a start transfers when start_i & ready_o at a rising clk edge; a product transfers when res_valid_o & res_ready_i.
interface otbn_mac_bignum_mulseq_if #(
    parameter int WLEN = 256
);
    logic                start_i;
    logic                ready_o;
    logic [WLEN-1:0]     op_a_i;
    logic [WLEN-1:0]     op_b_i;
    logic                res_valid_o;
    logic                res_ready_i;
    logic [2*WLEN-1:0]   res_o;
    logic                mac_en_o;
    logic                mac_commit_o;
    logic [WLEN-1:0]     mac_op_a_o;
    logic [WLEN-1:0]     mac_op_b_o;
    logic [1:0]          mac_a_qw_sel_o;
    logic [1:0]          mac_b_qw_sel_o;
    logic [1:0]          mac_shift_imm_o;
    logic                mac_zero_acc_o;
    logic                mac_shift_acc_o;
    logic                mac_wr_hw_sel_upper_o;
    logic                mac_predec_op_en_o;
    logic                mac_predec_acc_rd_en_o;
    logic [WLEN-1:0]     mac_result_i;
    logic                mac_intg_err_i;
    logic                mac_predec_err_i;
    logic                sec_wipe_acc_urnd_o;
    logic                err_o;
    logic [2:0]          dbg_state_o;

    modport slave (
        input  start_i, op_a_i, op_b_i, res_ready_i, mac_result_i, mac_intg_err_i, mac_predec_err_i,
        output ready_o, res_valid_o, res_o, mac_en_o, mac_commit_o, mac_op_a_o, mac_op_b_o,
               mac_a_qw_sel_o, mac_b_qw_sel_o, mac_shift_imm_o, mac_zero_acc_o, mac_shift_acc_o,
               mac_wr_hw_sel_upper_o, mac_predec_op_en_o, mac_predec_acc_rd_en_o,
               sec_wipe_acc_urnd_o, err_o, dbg_state_o
    );

    modport master (
        output start_i, op_a_i, op_b_i, res_ready_i, mac_result_i, mac_intg_err_i, mac_predec_err_i,
        input  ready_o, res_valid_o, res_o, mac_en_o, mac_commit_o, mac_op_a_o, mac_op_b_o,
               mac_a_qw_sel_o, mac_b_qw_sel_o, mac_shift_imm_o, mac_zero_acc_o, mac_shift_acc_o,
               mac_wr_hw_sel_upper_o, mac_predec_op_en_o, mac_predec_acc_rd_en_o,
               sec_wipe_acc_urnd_o, err_o, dbg_state_o
    );
endinterface

// File: rtl/otbn_mac_bignum_mulseq.sv
// Drives the 16-step quarter-word schedule on the bignum MAC and assembles the 2*WLEN product.
// Optional accumulator wipe after the last step when OTBN_MULSEQ_SEC_WIPE_EN is defined.
module otbn_mac_bignum_mulseq #(
    parameter int WLEN = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    otbn_mac_bignum_mulseq_if.slave  bus
);
    localparam int QWLEN = WLEN / 4;
    localparam int HW    = 2 * QWLEN;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
`ifdef OTBN_MULSEQ_SEC_WIPE_EN
        ST_WIPE  = 3'd2,
`endif
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_step;
    logic [WLEN-1:0]     r_op_a;
    logic [WLEN-1:0]     r_op_b;
    logic [2*WLEN-1:0]   r_res;

    logic [5:0]          w_sched;
    logic                w_so;
    logic [1:0]          w_res_sel;
    logic                w_run;
    logic                w_accept;
    logic                w_err_in;
    logic                w_unused_result;

    assign w_run           = (r_state == ST_RUN);
    assign w_accept        = (r_state == ST_IDLE) & bus.start_i;
    assign w_err_in        = bus.mac_intg_err_i | bus.mac_predec_err_i;
    assign w_unused_result = ^bus.mac_result_i[WLEN-1:HW];

    // {a_qw, b_qw, shift}; .SO steps fold the low half-word out into the product.
    always_comb begin
        w_sched   = 6'b00_00_00;
        w_so      = 1'b0;
        w_res_sel = 2'd0;
        case (r_step)
            4'd0:  w_sched = 6'b00_00_00;
            4'd1:  w_sched = 6'b01_00_01;
            4'd2:  begin w_sched = 6'b00_01_01; w_so = 1'b1; w_res_sel = 2'd0; end
            4'd3:  w_sched = 6'b10_00_00;
            4'd4:  w_sched = 6'b01_01_00;
            4'd5:  w_sched = 6'b00_10_00;
            4'd6:  w_sched = 6'b11_00_01;
            4'd7:  w_sched = 6'b10_01_01;
            4'd8:  w_sched = 6'b01_10_01;
            4'd9:  begin w_sched = 6'b00_11_01; w_so = 1'b1; w_res_sel = 2'd1; end
            4'd10: w_sched = 6'b11_01_00;
            4'd11: w_sched = 6'b10_10_00;
            4'd12: w_sched = 6'b01_11_00;
            4'd13: w_sched = 6'b11_10_01;
            4'd14: begin w_sched = 6'b10_11_01; w_so = 1'b1; w_res_sel = 2'd2; end
            default: begin w_sched = 6'b11_11_00; w_so = 1'b1; w_res_sel = 2'd3; end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start_i) w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_err_in) begin
                    w_state_next = ST_ERROR;
                end else if (r_step == 4'd15) begin
`ifdef OTBN_MULSEQ_SEC_WIPE_EN
                    w_state_next = ST_WIPE;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
`ifdef OTBN_MULSEQ_SEC_WIPE_EN
            ST_WIPE:  w_state_next = ST_DONE;
`endif
            ST_DONE:  if (bus.res_ready_i) w_state_next = ST_IDLE;
            ST_ERROR: w_state_next = ST_ERROR;
            default:  w_state_next = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_step <= 4'd0;
            r_op_a <= '0;
            r_op_b <= '0;
            r_res  <= '0;
        end else if (w_accept) begin
            r_step <= 4'd0;
            r_op_a <= bus.op_a_i;
            r_op_b <= bus.op_b_i;
            r_res  <= '0;
        end else if (w_run) begin
            r_step <= r_step + 4'd1;
            if (w_so) r_res[32'(w_res_sel) * HW +: HW] <= bus.mac_result_i[HW-1:0];
        end
    end

    // ready_o is masked by reset so every output reads 0 while rst_i is high.
    assign bus.ready_o                = (r_state == ST_IDLE) & ~rst_i;
    assign bus.res_valid_o            = (r_state == ST_DONE);
    assign bus.res_o                  = r_res;
    assign bus.err_o                  = (r_state == ST_ERROR);
    assign bus.mac_en_o               = w_run;
    assign bus.mac_commit_o           = w_run;
    assign bus.mac_op_a_o             = w_run ? r_op_a : '0;
    assign bus.mac_op_b_o             = w_run ? r_op_b : '0;
    assign bus.mac_a_qw_sel_o         = w_run ? w_sched[5:4] : 2'd0;
    assign bus.mac_b_qw_sel_o         = w_run ? w_sched[3:2] : 2'd0;
    assign bus.mac_shift_imm_o        = w_run ? w_sched[1:0] : 2'd0;
    assign bus.mac_zero_acc_o         = w_run & (r_step == 4'd0);
    assign bus.mac_shift_acc_o        = w_run & w_so;
    assign bus.mac_wr_hw_sel_upper_o  = w_run & w_so & w_res_sel[0];
    assign bus.mac_predec_op_en_o     = w_run;
    assign bus.mac_predec_acc_rd_en_o = w_run & ~(r_step == 4'd0);
    assign bus.dbg_state_o            = r_state;
`ifdef OTBN_MULSEQ_SEC_WIPE_EN
    assign bus.sec_wipe_acc_urnd_o    = (r_state == ST_WIPE);
`else
    assign bus.sec_wipe_acc_urnd_o    = 1'b0;
`endif
endmodule

// File: tb/tb_otbn_mac_bignum_mulseq.sv
// Bench for otbn_mac_bignum_mulseq: behavioural bignum MAC, directed products, queued expected results.
module tb_otbn_mac_bignum_mulseq;
  localparam int WLEN = 256;
  localparam logic [5:0] SCHED [16] = '{
    6'b00_00_00, 6'b01_00_01, 6'b00_01_01, 6'b10_00_00,
    6'b01_01_00, 6'b00_10_00, 6'b11_00_01, 6'b10_01_01,
    6'b01_10_01, 6'b00_11_01, 6'b11_01_00, 6'b10_10_00,
    6'b01_11_00, 6'b11_10_01, 6'b10_11_01, 6'b11_11_00
  };

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2*WLEN-1:0] exp_q[$];
  logic [2*WLEN-1:0] mon_exp;

  otbn_mac_bignum_mulseq_if #(.WLEN(WLEN)) bus ();

  otbn_mac_bignum_mulseq #(.WLEN(WLEN)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // behavioural bignum MAC: quarter-word product, pre-shift, accumulate, optional .Z / .SO
  logic [WLEN-1:0] mac_acc = '0;
  logic [127:0]    mac_prod;
  logic [WLEN-1:0] mac_sum;

  always_comb begin
    mac_prod = 128'(bus.mac_op_a_o[{bus.mac_a_qw_sel_o, 6'b0} +: 64]) *
               128'(bus.mac_op_b_o[{bus.mac_b_qw_sel_o, 6'b0} +: 64]);
    mac_sum  = (bus.mac_zero_acc_o ? '0 : mac_acc) + (WLEN'(mac_prod) << {bus.mac_shift_imm_o, 6'b0});
  end
  assign bus.mac_result_i = mac_sum;

  always @(posedge clk_i) begin
    if (bus.mac_en_o && bus.mac_commit_o)
      mac_acc <= bus.mac_shift_acc_o ? (mac_sum >> 128) : mac_sum;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i && bus.res_valid_o && bus.res_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.res_o);
      end else begin
        mon_exp = exp_q.pop_front();
        checkw("result", bus.res_o, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check1({name, "_en"}, bus.mac_en_o, 1'b0);
    check1({name, "_commit"}, bus.mac_commit_o, 1'b0);
    checkw({name, "_op_a"}, 512'(bus.mac_op_a_o), '0);
    check1({name, "_valid"}, bus.res_valid_o, 1'b0);
  endtask

  task automatic run_op(input logic [WLEN-1:0] a, input logic [WLEN-1:0] b,
                        input logic [2*WLEN-1:0] exp, input int stall);
    next_cycle();
    bus.start_i = 1'b1;
    bus.op_a_i = a;
    bus.op_b_i = b;
    bus.res_ready_i = (stall == 0);
    @(negedge clk_i);
    check1("ready_c0", bus.ready_o, 1'b1);
    exp_q.push_back(exp);
    for (int s = 0; s < 16; s++) begin
      next_cycle();
      bus.start_i = 1'b0;
      bus.op_a_i = '0;
      bus.op_b_i = '0;
      @(negedge clk_i);
      check1("run_en", bus.mac_en_o, 1'b1);
      check1("run_commit", bus.mac_commit_o, 1'b1);
      check1("run_ready", bus.ready_o, 1'b0);
      check1("run_valid", bus.res_valid_o, 1'b0);
      checkw("run_op_a", 512'(bus.mac_op_a_o), 512'(a));
      checkw("run_op_b", 512'(bus.mac_op_b_o), 512'(b));
      checkw("sched", 512'({bus.mac_a_qw_sel_o, bus.mac_b_qw_sel_o, bus.mac_shift_imm_o}), 512'(SCHED[s]));
      check1("zero_acc", bus.mac_zero_acc_o, s == 0);
      check1("shift_acc", bus.mac_shift_acc_o, s == 2 || s == 9 || s == 14 || s == 15);
      check1("hw_upper", bus.mac_wr_hw_sel_upper_o, s == 9 || s == 15);
      check1("predec_op_en", bus.mac_predec_op_en_o, 1'b1);
      check1("predec_acc_rd", bus.mac_predec_acc_rd_en_o, s != 0);
      check1("run_wipe", bus.sec_wipe_acc_urnd_o, 1'b0);
    end
`ifdef OTBN_MULSEQ_SEC_WIPE_EN
    next_cycle();
    @(negedge clk_i);
    check1("wipe_req", bus.sec_wipe_acc_urnd_o, 1'b1);
    check1("wipe_en", bus.mac_en_o, 1'b0);
    check1("wipe_valid", bus.res_valid_o, 1'b0);
`endif
    next_cycle();
    @(negedge clk_i);
    check1("done_valid", bus.res_valid_o, 1'b1);
    check1("done_ready", bus.ready_o, 1'b0);
    check1("done_wipe", bus.sec_wipe_acc_urnd_o, 1'b0);
    for (int i = 0; i < stall; i++) begin
      next_cycle();
      bus.start_i = (i == 4);
      @(negedge clk_i);
      check1("hold_valid", bus.res_valid_o, 1'b1);
      check1("hold_ready", bus.ready_o, 1'b0);
      checkw("hold_res", bus.res_o, exp);
    end
    if (stall > 0) begin
      next_cycle();
      bus.start_i = 1'b0;
      bus.res_ready_i = 1'b1;
      @(negedge clk_i);
      check1("accept_valid", bus.res_valid_o, 1'b1);
    end
    next_cycle();
    @(negedge clk_i);
    check1("after_valid", bus.res_valid_o, 1'b0);
    check1("after_ready", bus.ready_o, 1'b1);
  endtask

  task automatic err_run(input int inj_cycle, input logic use_predec);
    next_cycle();
    bus.start_i = 1'b1;
    bus.op_a_i = 256'd11;
    bus.op_b_i = 256'd13;
    bus.res_ready_i = 1'b1;
    for (int c = 1; c <= inj_cycle; c++) begin
      next_cycle();
      bus.start_i = 1'b0;
      if (c == inj_cycle) begin
        if (use_predec) bus.mac_predec_err_i = 1'b1;
        else bus.mac_intg_err_i = 1'b1;
      end
      @(negedge clk_i);
      check1("pre_err", bus.err_o, 1'b0);
      check1("pre_err_en", bus.mac_en_o, 1'b1);
    end
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      bus.mac_intg_err_i = 1'b0;
      bus.mac_predec_err_i = 1'b0;
      bus.start_i = (c == 5);
      @(negedge clk_i);
      check1("err_sticky", bus.err_o, 1'b1);
      check1("err_ready", bus.ready_o, 1'b0);
      check_idle_outputs("err");
    end
    bus.start_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check1("rst_err", bus.err_o, 1'b0);
    check1("rst_ready", bus.ready_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.op_a_i = '0;
    bus.op_b_i = '0;
    bus.res_ready_i = 1'b1;
    bus.mac_intg_err_i = 1'b0;
    bus.mac_predec_err_i = 1'b0;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check1("reset_ready", bus.ready_o, 1'b0);
    check1("reset_err", bus.err_o, 1'b0);
    check1("reset_wipe", bus.sec_wipe_acc_urnd_o, 1'b0);
    checkw("reset_res", bus.res_o, '0);
    checkw("reset_state", 512'(bus.dbg_state_o), '0);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check1("ready_after_reset", bus.ready_o, 1'b1);

    run_op(256'd3, 256'd5, 512'd15, 0);
    run_op({256{1'b1}}, {256{1'b1}}, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, 0);
    run_op(256'(1) << 255, 256'd2, 512'(1) << 256, 10);

    err_run(6, 1'b0);
    pulse_reset();
    err_run(3, 1'b1);
    pulse_reset();

    // abort in s8 (cycle 9) and check that the next product carries no residue
    next_cycle();
    bus.start_i = 1'b1;
    bus.op_a_i = {256{1'b1}};
    bus.op_b_i = 256'hdead_beef_0123_4567_89ab_cdef;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      bus.start_i = 1'b0;
    end
    next_cycle();
    rst_i = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check1("midrst_ready", bus.ready_o, 1'b0);
    check1("midrst_so", bus.mac_shift_acc_o, 1'b0);
    checkw("midrst_res", bus.res_o, '0);
    checkw("midrst_state", 512'(bus.dbg_state_o), '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(256'd7, 256'd9, 512'd63, 0);

    checkw("queue_empty", 512'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
